cache_fill_wb_fsm: RTL and testbench

Parametrised cache miss handler sitting between a cache's tag/data arrays and a pipelined main memory. On a miss it optionally writes back a dirty victim block, then fills the missing block by issuing one read request per cycle and absorbing in-order responses with arbitrary gaps. It drives data-array write enables per word and commits the tag last. This is the successor to the fixed 8-word, read-only fill FSM: block geometry is configurable, reads are pipelined, and dirty write-back is supported.

---
 rtl/cache_fill_wb_fsm_if.sv | 23 ++
 rtl/cache_fill_wb_fsm.sv | 136 +++++++++++++
 tb/tb_cache_fill_wb_fsm.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_wb_fsm_if.sv
// Memory-side bus of the cache miss handler: pipelined single-word reads with
// in-order responses, and single-word writes for dirty-victim write-back.
interface cache_fill_wb_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] memory_address;
  logic              memory_read;
  logic              memory_write;
  logic [DATA_W-1:0] memory_wdata;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;

  modport master (
    output memory_address, memory_read, memory_write, memory_wdata,
    input  memory_data, memory_data_valid
  );

  modport slave (
    input  memory_address, memory_read, memory_write, memory_wdata,
    output memory_data, memory_data_valid
  );
endinterface

// File: rtl/cache_fill_wb_fsm.sv
// Cache miss handler: optional dirty-victim write-back, then a pipelined block
// fill that writes data-array words as responses arrive and commits the tag last.
module cache_fill_wb_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     victim_dirty,
  input  logic [ADDR_W-1:0]        victim_address,
  input  logic [DATA_W-1:0]        victim_data,
  output logic                     fsm_busy,
  output logic                     write_data_array,
  output logic                     write_tag_array,
  output logic [$clog2(WORDS)-1:0] word_num,
  output logic                     fill_done,
  cache_fill_wb_fsm_if.master      mem
);

  localparam int BPW   = DATA_W / 8;
  localparam int WN_W  = $clog2(WORDS);
  localparam int OFF   = $clog2(WORDS * BPW);
  localparam int CNT_W = WN_W + 1;

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFF) - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(BPW);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  fill_base, fill_base_d;
  logic [ADDR_W-1:0]  wb_base, wb_base_d;
  logic [CNT_W-1:0]   wb_cnt, wb_cnt_d;
  logic [CNT_W-1:0]   issue_cnt, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt, recv_cnt_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_base <= '0;
      wb_base   <= '0;
      wb_cnt    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_d;
      fill_base <= fill_base_d;
      wb_base   <= wb_base_d;
      wb_cnt    <= wb_cnt_d;
      issue_cnt <= issue_cnt_d;
      recv_cnt  <= recv_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d              = state;
    fill_base_d          = fill_base;
    wb_base_d            = wb_base;
    wb_cnt_d             = wb_cnt;
    issue_cnt_d          = issue_cnt;
    recv_cnt_d           = recv_cnt;
    fsm_busy             = 1'b0;
    write_data_array     = 1'b0;
    write_tag_array      = 1'b0;
    fill_done            = 1'b0;
    word_num             = '0;
    mem.memory_address   = '0;
    mem.memory_read      = 1'b0;
    mem.memory_write     = 1'b0;
    mem.memory_wdata     = '0;

    unique case (state)
      IDLE: begin
        if (miss_detected) begin
          fill_base_d = miss_address & BLK_MASK;
          wb_base_d   = victim_address & BLK_MASK;
          wb_cnt_d    = '0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = victim_dirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        fsm_busy           = 1'b1;
        mem.memory_write   = 1'b1;
        word_num           = wb_cnt[WN_W-1:0];
        mem.memory_address = wb_base + ADDR_W'(wb_cnt) * STRIDE;
        mem.memory_wdata   = victim_data;
        wb_cnt_d           = wb_cnt + ONE;
        if (wb_cnt == LAST) begin
          wb_cnt_d    = '0;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        word_num = recv_cnt[WN_W-1:0];
        // Requests stream out independently of responses; the two overlap.
        if (issue_cnt < FULL) begin
          mem.memory_read    = 1'b1;
          mem.memory_address = fill_base + ADDR_W'(issue_cnt) * STRIDE;
          issue_cnt_d        = issue_cnt + ONE;
        end
        if (mem.memory_data_valid) begin
          write_data_array = 1'b1;
          recv_cnt_d       = recv_cnt + ONE;
          if (recv_cnt == LAST) state_d = DONE;
        end
      end

      DONE: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_wb_fsm.sv
// Self-checking bench for cache_fill_wb_fsm: scoreboard of expected memory
// requests and array writes, with a pipelined memory model (latency, gaps).
module tb_cache_fill_wb_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 8-word, 16-bit instance
  logic        miss8 = 1'b0, vdirty8 = 1'b0;
  logic [15:0] maddr8 = '0, vaddr8 = '0, vdata8 = '0;
  logic        busy8, wda8, wta8, done8;
  logic [2:0]  wn8;
  cache_fill_wb_fsm_if #(.ADDR_W(16), .DATA_W(16)) mem8();

  cache_fill_wb_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss8), .miss_address(maddr8),
    .victim_dirty(vdirty8), .victim_address(vaddr8), .victim_data(vdata8),
    .fsm_busy(busy8), .write_data_array(wda8), .write_tag_array(wta8),
    .word_num(wn8), .fill_done(done8), .mem(mem8.master)
  );

  // 4-word, 32-bit instance
  logic        miss4 = 1'b0, vdirty4 = 1'b0;
  logic [15:0] maddr4 = '0, vaddr4 = '0;
  logic [31:0] vdata4 = '0;
  logic        busy4, wda4, wta4, done4;
  logic [1:0]  wn4;
  cache_fill_wb_fsm_if #(.ADDR_W(16), .DATA_W(32)) mem4();

  cache_fill_wb_fsm #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss4), .miss_address(maddr4),
    .victim_dirty(vdirty4), .victim_address(vaddr4), .victim_data(vdata4),
    .fsm_busy(busy4), .write_data_array(wda4), .write_tag_array(wta4),
    .word_num(wn4), .fill_done(done4), .mem(mem4.master)
  );

  initial begin
    mem8.memory_data = '0; mem8.memory_data_valid = 1'b0;
    mem4.memory_data = '0; mem4.memory_data_valid = 1'b0;
  end

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  int          checks = 0, errors = 0, cyc = 0;
  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];
  int          exp_wn_q[$];
  resp_t       resp_q[$];
  int          lat = 4;
  bit          gap_en = 1'b0;
  int          gap_idx = 0;
  bit [6:0]    gap_pat = 7'b1011001;  // 1,0,0,1,1,0,1 from bit 0 upward
  bit          stray = 1'b0;
  logic [15:0] data_base = '0;
  int          rd_idx = 0;
  logic [15:0] victim_mem[8];
  logic [15:0] cache_model[8];
  int          rd_n, wr_n, wda_n, tag_n;
  int          rd_first, rd_last, wr_first, wr_last, wda_last, done_cyc, idle_cyc;

  task automatic clear_stats();
    exp_rd_q.delete(); exp_wr_q.delete(); exp_wn_q.delete(); resp_q.delete();
    rd_n = 0; wr_n = 0; wda_n = 0; tag_n = 0; rd_idx = 0; gap_idx = 0;
    rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
    wda_last = -1; done_cyc = -1; idle_cyc = -1;
    for (int i = 0; i < 8; i++) cache_model[i] = 'x;
  endtask

  // One clock of the 8-word instance: memory model drives, then outputs are
  // sampled 2 time units after the rising edge and scored.
  task automatic cycle8();
    bit          allow;
    logic [15:0] e_rd;
    logic [31:0] e_wr;
    int          e_wn;
    @(posedge clk); #1; cyc++;
    mem8.memory_data_valid = 1'b0;
    mem8.memory_data       = '0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      allow = gap_en ? gap_pat[gap_idx] : 1'b1;
      if (gap_en) gap_idx = (gap_idx + 1) % 7;
      if (allow) begin
        mem8.memory_data_valid = 1'b1;
        mem8.memory_data       = resp_q[0].data;
        void'(resp_q.pop_front());
      end
    end else if (stray) begin
      mem8.memory_data_valid = 1'b1;
      mem8.memory_data       = 16'hBAD0;
    end
    vdata8 = victim_mem[wn8];
    #1;

    if (mem8.memory_read) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_addr: unexpected read of %h at cycle %0d, required no read", mem8.memory_address, cyc);
      end else begin
        e_rd = exp_rd_q.pop_front();
        if (mem8.memory_address !== e_rd) begin
          errors++;
          $display("FAIL rd_addr: got %h required %h at cycle %0d", mem8.memory_address, e_rd, cyc);
        end
      end
      if (rd_n == 0) rd_first = cyc;
      rd_last = cyc; rd_n++;
      resp_q.push_back('{due: cyc + lat, data: data_base + 16'(rd_idx)});
      rd_idx++;
      checks++;
      if (mem8.memory_write !== 1'b0) begin
        errors++;
        $display("FAIL rd_wr_overlap: memory_write=%b with memory_read at cycle %0d, required 0", mem8.memory_write, cyc);
      end
    end

    if (mem8.memory_write) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr: unexpected write of %h to %h at cycle %0d", mem8.memory_wdata, mem8.memory_address, cyc);
      end else begin
        e_wr = exp_wr_q.pop_front();
        if ({mem8.memory_address, mem8.memory_wdata} !== e_wr) begin
          errors++;
          $display("FAIL wr: got addr %h data %h required addr %h data %h at cycle %0d",
                   mem8.memory_address, mem8.memory_wdata, e_wr[31:16], e_wr[15:0], cyc);
        end
      end
      if (wr_n == 0) wr_first = cyc;
      wr_last = cyc; wr_n++;
      checks++;
      if (wda8 !== 1'b0) begin
        errors++;
        $display("FAIL wda_in_wb: write_data_array=%b during write-back at cycle %0d, required 0", wda8, cyc);
      end
    end

    if (wda8) begin
      checks++;
      if (exp_wn_q.size() == 0) begin
        errors++;
        $display("FAIL wda_word: unexpected array write of word %0d at cycle %0d", wn8, cyc);
      end else begin
        e_wn = exp_wn_q.pop_front();
        if (int'(wn8) !== e_wn) begin
          errors++;
          $display("FAIL wda_word: got word_num %0d required %0d at cycle %0d", wn8, e_wn, cyc);
        end
      end
      cache_model[wn8] = mem8.memory_data;
      wda_n++; wda_last = cyc;
    end

    if (wta8 || done8) begin
      checks++;
      if (!(wta8 && done8 && busy8)) begin
        errors++;
        $display("FAIL done_pulse: tag=%b done=%b busy=%b at cycle %0d, required 1 1 1", wta8, done8, busy8, cyc);
      end
      tag_n++; done_cyc = cyc;
    end

    if (!busy8) begin
      if (done_cyc >= 0 && idle_cyc < done_cyc) idle_cyc = cyc;
      checks++;
      if ({mem8.memory_read, mem8.memory_write, wda8, wta8, done8, wn8, mem8.memory_address, mem8.memory_wdata} !== '0) begin
        errors++;
        $display("FAIL idle_outputs: rd=%b wr=%b wda=%b tag=%b done=%b wn=%0d addr=%h wdata=%h at cycle %0d, required all 0",
                 mem8.memory_read, mem8.memory_write, wda8, wta8, done8, wn8, mem8.memory_address, mem8.memory_wdata, cyc);
      end
    end
  endtask

  task automatic start_miss8(input logic [15:0] addr, input bit dirty, input logic [15:0] vaddr,
                             input int nfills, output int acc);
    for (int f = 0; f < nfills; f++)
      for (int i = 0; i < 8; i++) begin
        exp_rd_q.push_back((addr & 16'hFFF0) + 16'(2 * i));
        exp_wn_q.push_back(i);
      end
    if (dirty)
      for (int i = 0; i < 8; i++)
        exp_wr_q.push_back({(vaddr & 16'hFFF0) + 16'(2 * i), victim_mem[i]});
    maddr8 = addr; vaddr8 = vaddr; vdirty8 = dirty; miss8 = 1'b1;
    cycle8();
    acc = cyc;
  endtask

  task automatic wait_done8(input int target, input string name);
    int n = 0;
    while (!(tag_n >= target && !busy8) && n < 200) begin
      cycle8(); n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_timeout: %0d tag writes busy=%b after %0d cycles, required %0d and idle", name, tag_n, busy8, n, target);
    end
  endtask

  task automatic end_checks(input int acc, input bit dirty, input string name);
    checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || exp_wn_q.size() != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: reads=%0d writes=%0d words=%0d responses=%0d outstanding, required 0", name,
               exp_rd_q.size(), exp_wr_q.size(), exp_wn_q.size(), resp_q.size());
    end
    checks++;
    if (tag_n !== 1) begin
      errors++;
      $display("FAIL %s_tag_count: got %0d tag writes, required 1", name, tag_n);
    end
    checks++;
    if (dirty ? (wr_first !== acc || wr_last !== acc + 7 || rd_first !== acc + 8) : (rd_first !== acc)) begin
      errors++;
      $display("FAIL %s_timing: writes %0d..%0d reads from %0d, miss took effect at %0d (required %s)", name,
               wr_first, wr_last, rd_first, acc, dirty ? "writes acc..acc+7, reads from acc+8" : "reads from acc");
    end
    checks++;
    if (rd_last !== rd_first + 7) begin
      errors++;
      $display("FAIL %s_read_burst: reads %0d..%0d, required 8 consecutive cycles", name, rd_first, rd_last);
    end
    checks++;
    if (done_cyc !== wda_last + 1) begin
      errors++;
      $display("FAIL %s_done_cycle: done at %0d, last array write at %0d, required the next cycle", name, done_cyc, wda_last);
    end
    checks++;
    if (idle_cyc !== done_cyc + 1) begin
      errors++;
      $display("FAIL %s_busy_drop: idle at %0d, done at %0d, required done+1", name, idle_cyc, done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cache_model[i] !== data_base + 16'(i)) begin
        errors++;
        $display("FAIL %s_data[%0d]: array holds %h required %h", name, i, cache_model[i], data_base + 16'(i));
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({busy8, wda8, wta8, done8, wn8, mem8.memory_read, mem8.memory_write, mem8.memory_address, mem8.memory_wdata} !== '0) begin
      errors++;
      $display("FAIL reset8: busy=%b wda=%b tag=%b done=%b wn=%0d rd=%b wr=%b addr=%h wdata=%h, required all 0",
               busy8, wda8, wta8, done8, wn8, mem8.memory_read, mem8.memory_write, mem8.memory_address, mem8.memory_wdata);
    end
    checks++;
    if ({busy4, wda4, wta4, done4, wn4, mem4.memory_read, mem4.memory_write, mem4.memory_address, mem4.memory_wdata} !== '0) begin
      errors++;
      $display("FAIL reset4: busy=%b rd=%b wr=%b addr=%h wdata=%h, required all 0",
               busy4, mem4.memory_read, mem4.memory_write, mem4.memory_address, mem4.memory_wdata);
    end
    clear_stats();
    repeat (2) cycle8();
    rst_n = 1'b1;
    cycle8();
  endtask

  task automatic test_clean();
    int acc;
    clear_stats(); lat = 4; data_base = 16'h4567;
    start_miss8(16'h0046, 1'b0, 16'h0000, 1, acc);
    miss8 = 1'b0;
    wait_done8(1, "clean");
    end_checks(acc, 1'b0, "clean");
  endtask

  task automatic test_dirty();
    int acc;
    clear_stats(); lat = 3; data_base = 16'h1000;
    for (int i = 0; i < 8; i++) victim_mem[i] = 16'($urandom);
    start_miss8(16'h0046, 1'b1, 16'h1234, 1, acc);
    miss8 = 1'b0;
    wait_done8(1, "dirty");
    end_checks(acc, 1'b1, "dirty");
  endtask

  task automatic test_gapped();
    int acc;
    clear_stats(); lat = 2; data_base = 16'h7700; gap_en = 1'b1;
    start_miss8(16'h0102, 1'b0, 16'h0000, 1, acc);
    miss8 = 1'b0;
    wait_done8(1, "gapped");
    end_checks(acc, 1'b0, "gapped");
    gap_en = 1'b0;
  endtask

  task automatic test_ignore();
    int acc;
    clear_stats(); lat = 5; data_base = 16'h3300;
    for (int i = 0; i < 8; i++) victim_mem[i] = 16'(16'hC000 + i * 16'h0111);
    start_miss8(16'h0080, 1'b1, 16'h2000, 1, acc);
    miss8 = 1'b0; stray = 1'b1;
    repeat (3) cycle8();
    maddr8 = 16'h3000; vdirty8 = 1'b0; miss8 = 1'b1;
    cycle8();
    miss8 = 1'b0;
    cycle8();
    stray = 1'b0;
    wait_done8(1, "ignore");
    stray = 1'b1;
    repeat (3) cycle8();
    stray = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle_valid: busy=%b after stray valid in idle, required 0", busy8);
    end
    idle_cyc = done_cyc + 1;  // stray cycles above are all idle; keep first idle
    end_checks(acc, 1'b1, "ignore");
  endtask

  task automatic test_hold_miss();
    int acc, acc2, idle1, n;
    clear_stats(); lat = 1; data_base = 16'h2000;
    start_miss8(16'h0046, 1'b0, 16'h0000, 2, acc);
    n = 0;
    while (tag_n < 1 && n < 100) begin cycle8(); n++; end
    n = 0;
    while (!(idle_cyc > done_cyc && busy8) && n < 10) begin cycle8(); n++; end
    miss8 = 1'b0;
    acc2 = cyc; idle1 = idle_cyc;
    checks++;
    if (acc2 !== idle1 + 1) begin
      errors++;
      $display("FAIL hold_reaccept: second fill busy at %0d, idle at %0d, required idle+1", acc2, idle1);
    end
    wait_done8(2, "hold");
    checks++;
    if (tag_n !== 2 || exp_rd_q.size() != 0 || exp_wn_q.size() != 0) begin
      errors++;
      $display("FAIL hold_fills: %0d tag writes, %0d reads and %0d words outstanding, required 2,0,0",
               tag_n, exp_rd_q.size(), exp_wn_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cache_model[i] !== data_base + 16'(8 + i)) begin
        errors++;
        $display("FAIL hold_data[%0d]: array holds %h required %h", i, cache_model[i], data_base + 16'(8 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, n;
    clear_stats(); lat = 4; data_base = 16'h5000;
    start_miss8(16'h0046, 1'b0, 16'h0000, 1, acc);
    miss8 = 1'b0;
    n = 0;
    while (wda_n < 3 && n < 50) begin cycle8(); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, wda8, wta8, done8, wn8, mem8.memory_read, mem8.memory_write, mem8.memory_address, mem8.memory_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b wda=%b tag=%b done=%b wn=%0d rd=%b wr=%b addr=%h, required all 0 immediately",
               busy8, wda8, wta8, done8, wn8, mem8.memory_read, mem8.memory_write, mem8.memory_address);
    end
    clear_stats();
    cycle8();
    rst_n = 1'b1;
    repeat (4) cycle8();
    checks++;
    if (tag_n !== 0 || rd_n !== 0) begin
      errors++;
      $display("FAIL reset_abort: %0d tag writes and %0d reads after reset, required 0", tag_n, rd_n);
    end
    clear_stats(); data_base = 16'h6000;
    start_miss8(16'h0046, 1'b0, 16'h0000, 1, acc);
    miss8 = 1'b0;
    wait_done8(1, "restart");
    end_checks(acc, 1'b0, "restart");
  endtask

  task automatic test_words4();
    logic [15:0] e4_rd[$];
    int          e4_wn[$];
    int          due4[$];
    logic [31:0] dat4[$];
    logic [31:0] c4model[4];
    logic [15:0] e_rd;
    int          e_wn, c4, done4_n, rd4_n;
    bit          fin;
    c4 = 0; done4_n = 0; rd4_n = 0; fin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e4_rd.push_back(16'h00F0 + 16'(4 * i));
      e4_wn.push_back(i);
      c4model[i] = 'x;
    end
    maddr4 = 16'h00F7; vdirty4 = 1'b0; miss4 = 1'b1;
    for (int n = 0; n < 40 && !fin; n++) begin
      @(posedge clk); #1; c4++;
      miss4 = 1'b0;
      mem4.memory_data_valid = 1'b0;
      mem4.memory_data       = '0;
      if (due4.size() > 0 && due4[0] <= c4) begin
        mem4.memory_data_valid = 1'b1;
        mem4.memory_data       = dat4.pop_front();
        void'(due4.pop_front());
      end
      #1;
      if (mem4.memory_read) begin
        checks++;
        if (e4_rd.size() == 0) begin
          errors++;
          $display("FAIL w4_rd_addr: unexpected read of %h", mem4.memory_address);
        end else begin
          e_rd = e4_rd.pop_front();
          if (mem4.memory_address !== e_rd) begin
            errors++;
            $display("FAIL w4_rd_addr: got %h required %h", mem4.memory_address, e_rd);
          end
        end
        due4.push_back(c4 + 2);
        dat4.push_back(32'hA000_0000 + 32'(rd4_n));
        rd4_n++;
      end
      if (wda4) begin
        checks++;
        if (e4_wn.size() == 0) begin
          errors++;
          $display("FAIL w4_word: unexpected array write of word %0d", wn4);
        end else begin
          e_wn = e4_wn.pop_front();
          if (int'(wn4) !== e_wn) begin
            errors++;
            $display("FAIL w4_word: got word_num %0d required %0d", wn4, e_wn);
          end
        end
        c4model[wn4] = mem4.memory_data;
      end
      if (done4 && wta4) done4_n++;
      if (done4_n > 0 && !busy4) fin = 1'b1;
    end
    checks++;
    if (!fin || done4_n !== 1 || e4_rd.size() != 0 || e4_wn.size() != 0) begin
      errors++;
      $display("FAIL w4_complete: finished=%b done pulses=%0d reads left=%0d words left=%0d, required 1,1,0,0",
               fin, done4_n, e4_rd.size(), e4_wn.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (c4model[i] !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL w4_data[%0d]: array holds %h required %h", i, c4model[i], 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) victim_mem[i] = '0;
    test_reset();
    test_clean();
    test_dirty();
    test_gapped();
    test_ignore();
    test_hold_miss();
    test_reset_mid();
    test_words4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
